// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one registered-output ALU between NUM_REQ requesters.
// One operation is outstanding at a time; results return on a tagged response channel.
module alu_op_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int ALU_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [3*NUM_REQ-1:0]  req_opcode,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [2:0]            alu_opcode,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    input  logic [31:0]           alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_illegal,
    output logic                  busy
);

    localparam int CNT_W = $clog2(ALU_LATENCY + 2) + 1;
    localparam logic [2:0] OP_NONE = 3'b111;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       res_q, res_d;
    logic              ill_q, ill_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [2:0]        grant_op;

    // Search from the round-robin pointer upward, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    assign grant_op = req_opcode[3*grant_idx +: 3];

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && rst_n && grant_found) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        res_d   = res_q;
        ill_d   = ill_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    op_d = grant_op;
                    a_d  = req_a[32*grant_idx +: 32];
                    b_d  = req_b[32*grant_idx +: 32];
                    id_d = grant_idx;
                    rr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                    if (grant_op == OP_NONE) begin
                        res_d   = '0;
                        ill_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        cnt_d   = CNT_W'(ALU_LATENCY + 1);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = alu_result;
                    ill_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rr_q    <= '0;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            res_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
        end
    end

    // The ALU only sees a real opcode while waiting; 111 elsewhere keeps alu_result frozen.
    assign alu_opcode  = (state_q == StWait) ? op_q : OP_NONE;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_id      = id_q;
    assign rsp_result  = res_q;
    assign rsp_illegal = ill_q;
    assign busy        = (state_q != StIdle);

endmodule
